// File: rtl/ans_iq_pkg.sv
// Shared defaults, saturation limits and the IQ sample type for the IQ scaler.
// The optional rounding build is selected with ANS_IQ_SCALER_ROUND_EN.
package ans_iq_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int SHIFT_W_DEF = 3;
    localparam int CNT_W_DEF   = 16;

    localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

    // Raw two's-complement I/Q pair at the default width.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] i;
        logic [DATA_W_DEF-1:0] q;
    } iq_sample_t;

endpackage

// File: rtl/ans_sat_shift.sv
// Single-lane combinational shift with clamp and saturation flag.
// ANS_IQ_SCALER_ROUND_EN selects round-half-up for right shifts; otherwise they truncate.
module ans_sat_shift
    import ans_iq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic signed [DATA_W-1:0]  i_x,
    input  logic signed [SHIFT_W-1:0] i_shift,
    output logic signed [DATA_W-1:0]  o_y,
    output logic                      o_sat
);

    localparam logic signed [DATA_W-1:0] LIM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] LIM_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic                       w_neg;
    logic signed [SHIFT_W:0]    w_code;
    logic        [SHIFT_W:0]    w_mag;
    logic                       w_big;
    logic signed [2*DATA_W-1:0] w_wide;
    logic        [DATA_W:0]     w_hi;
    logic                       w_lovf;

    assign w_neg  = i_shift[SHIFT_W-1];
    assign w_code = {i_shift[SHIFT_W-1], i_shift};
    assign w_mag  = w_neg ? (~w_code + 1'b1) : w_code;
    assign w_big  = 32'(w_mag) >= DATA_W;

    // Left shift overflows unless every bit above the new sign bit matches it.
    assign w_wide = {{DATA_W{i_x[DATA_W-1]}}, i_x} << w_mag;
    assign w_hi   = w_wide[2*DATA_W-1:DATA_W-1];
    assign w_lovf = !((&w_hi) || !(|w_hi));

`ifdef ANS_IQ_SCALER_ROUND_EN
    logic        [DATA_W:0] w_half;
    logic signed [DATA_W:0] w_rsum;

    // One extra bit keeps x + 2^(k-1) from wrapping near the positive limit.
    assign w_half = {{DATA_W{1'b0}}, 1'b1} << (w_mag - 1'b1);
    assign w_rsum = $signed({i_x[DATA_W-1], i_x}) + $signed(w_half);
`endif

    always_comb begin
        o_y   = i_x;
        o_sat = 1'b0;
        if (w_neg) begin
`ifdef ANS_IQ_SCALER_ROUND_EN
            if (w_big) begin
                o_y = '0;
            end else begin
                o_y = DATA_W'(w_rsum >>> w_mag);
            end
`else
            if (w_big) begin
                o_y = {DATA_W{i_x[DATA_W-1]}};
            end else begin
                o_y = i_x >>> w_mag;
            end
`endif
        end else if (w_mag != '0) begin
            if (i_x == '0) begin
                o_y = '0;
            end else if (w_big || w_lovf) begin
                o_sat = 1'b1;
                o_y   = i_x[DATA_W-1] ? LIM_MIN : LIM_MAX;
            end else begin
                o_y = w_wide[DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ans_iq_scaler.sv
// Two-stage I/Q power-of-two scaler with valid/ready handshake and saturation counter.
// Build with ANS_IQ_SCALER_ROUND_EN for rounded right shifts (handled in ans_sat_shift).
module ans_iq_scaler
    import ans_iq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic signed [DATA_W-1:0]  in_i,
    input  logic signed [DATA_W-1:0]  in_q,
    input  logic signed [SHIFT_W-1:0] in_shift,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [DATA_W-1:0]  out_i,
    output logic signed [DATA_W-1:0]  out_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      sat_clr,
    output logic [CNT_W-1:0]          sat_cnt
);

    logic                      r_s1_valid;
    logic signed [DATA_W-1:0]  r_s1_i;
    logic signed [DATA_W-1:0]  r_s1_q;
    logic signed [SHIFT_W-1:0] r_s1_shift;

    logic                      r_out_valid;
    logic signed [DATA_W-1:0]  r_out_i;
    logic signed [DATA_W-1:0]  r_out_q;
    logic                      r_out_sat;
    logic [CNT_W-1:0]          r_sat_cnt;

    logic                      w_adv;
    logic                      w_out_xfer;
    logic signed [DATA_W-1:0]  w_i;
    logic signed [DATA_W-1:0]  w_q;
    logic                      w_sat_i;
    logic                      w_sat_q;

    // The whole pipe moves together; only a blocked output freezes it.
    assign w_adv      = !(r_out_valid && !out_ready);
    assign w_out_xfer = r_out_valid && out_ready;

    assign in_ready  = w_adv;
    assign out_i     = r_out_i;
    assign out_q     = r_out_q;
    assign out_valid = r_out_valid;
    assign sat_cnt   = r_sat_cnt;

    ans_sat_shift #(
        .DATA_W  (DATA_W),
        .SHIFT_W (SHIFT_W)
    ) u_lane_i (
        .i_x     (r_s1_i),
        .i_shift (r_s1_shift),
        .o_y     (w_i),
        .o_sat   (w_sat_i)
    );

    ans_sat_shift #(
        .DATA_W  (DATA_W),
        .SHIFT_W (SHIFT_W)
    ) u_lane_q (
        .i_x     (r_s1_q),
        .i_shift (r_s1_shift),
        .o_y     (w_q),
        .o_sat   (w_sat_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_i     <= '0;
            r_s1_q     <= '0;
            r_s1_shift <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_i     <= in_i;
                r_s1_q     <= in_q;
                r_s1_shift <= in_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_i   <= w_i;
                r_out_q   <= w_q;
                r_out_sat <= w_sat_i || w_sat_q;
            end
        end
    end

    // Clear wins over a coincident saturation event; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_out_xfer && r_out_sat && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ans_iq_scaler.sv
// Directed scoreboard bench for ans_iq_scaler (small counter width so the all-ones case is cheap).
// Expected values track ANS_IQ_SCALER_ROUND_EN when it is defined for the build.
module tb_ans_iq_scaler;
    import ans_iq_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] in_i, in_q, out_i, out_q;
    logic [2:0]  in_shift;
    logic        in_valid, in_ready, out_valid, out_ready, sat_clr;
    logic [3:0]  sat_cnt;

    int tests = 0;
    int fails = 0;
    int n_out = 0;
    iq_sample_t sb[$];
    iq_sample_t mon_exp;

    ans_iq_scaler #(
        .DATA_W  (16),
        .SHIFT_W (3),
        .CNT_W   (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_i      (in_i),
        .in_q      (in_q),
        .in_shift  (in_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: multiply / divide-by-power-of-two on wide integers.
    function automatic logic [15:0] model(input logic [15:0] x, input logic [2:0] code);
        longint v;
        int     c;
        v = longint'($signed(x));
        c = int'($signed(code));
        if (c < 0) begin
`ifdef ANS_IQ_SCALER_ROUND_EN
            v = v + (longint'(1) << (-c - 1));
`endif
            v = v >>> (-c);
        end else if (c > 0) begin
            v = v * (longint'(1) << c);
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
        end
        return v[15:0];
    endfunction

    always @(negedge clk) begin
        if (rstn && out_valid) begin
            if (out_ready) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mon_exp = sb.pop_front();
                    chk("out_i", out_i, mon_exp.i);
                    chk("out_q", out_q, mon_exp.q);
                    n_out++;
                end
            end else begin
                chk("stall_in_ready", in_ready, 0);
                if (sb.size() > 0) begin
                    chk("hold_i", out_i, sb[0].i);
                    chk("hold_q", out_q, sb[0].q);
                end
            end
        end
    end

    task automatic send_exp(input logic [15:0] i, input logic [15:0] q, input logic [2:0] code,
                            input logic [15:0] ei, input logic [15:0] eq);
        int n = 0;
        in_i     = i;
        in_q     = q;
        in_shift = code;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1);
        sb.push_back('{i: ei, q: eq});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_mod(input logic [15:0] i, input logic [15:0] q, input logic [2:0] code);
        send_exp(i, q, code, model(i, code), model(q, code));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int w;
        rstn = 1'b0; in_i = '0; in_q = '0; in_shift = '0;
        in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_out_i", out_i, 0);
        chk("rst_out_q", out_q, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1 chk("rel_in_ready", in_ready, 1);

        // Halving with exact two-cycle latency.
        send_exp(16'h4000, 16'hC000, 3'b111, 16'h2000, 16'hE000);
        @(negedge clk);
        chk("lat_c1", out_valid, 0);
        @(negedge clk);
        chk("lat_c2", out_valid, 1);
        @(posedge clk);
        #1 wait_drain();
        chk("sat_none", sat_cnt, 0);

        // Right-shift rounding behaviour on odd values.
`ifdef ANS_IQ_SCALER_ROUND_EN
        send_exp(16'h0003, 16'h0000, 3'b111, 16'h0002, 16'h0000);
        send_exp(16'hFFFD, 16'h0000, 3'b111, 16'hFFFF, 16'h0000);
`else
        send_exp(16'h0003, 16'h0000, 3'b111, 16'h0001, 16'h0000);
        send_exp(16'hFFFD, 16'h0000, 3'b111, 16'hFFFE, 16'h0000);
`endif
        wait_drain();

        // Left-shift clamping in both directions.
        send_exp(16'h4000, 16'h0001, 3'b010, 16'h7FFF, 16'h0004);
        wait_drain();
        chk("sat_cnt_1", sat_cnt, 1);
        send_exp(16'h8000, 16'h0000, 3'b001, 16'h8000, 16'h0000);
        wait_drain();
        chk("sat_cnt_2", sat_cnt, 2);

        // Eight-sample stream with a three-cycle downstream stall.
        n0 = n_out;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send_mod(16'($urandom), 16'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("stream_count", n_out - n0, 8);

        // Counter clear, saturation at all-ones, clear priority.
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        chk("clr", sat_cnt, 0);
        for (int k = 0; k < 17; k++)
            send_exp(16'h4000, 16'h4000, 3'b010, 16'h7FFF, 16'h7FFF);
        wait_drain();
        chk("sat_ones", sat_cnt, 4'hF);
        out_ready = 1'b0;
        send_exp(16'h4000, 16'h4000, 3'b010, 16'h7FFF, 16'h7FFF);
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("stall_fill", out_valid, 1);
        @(posedge clk);
        #1 sat_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        chk("clr_prio", sat_cnt, 0);

        // Asynchronous reset with samples in flight.
        send_exp(16'h4000, 16'h0000, 3'b011, 16'h7FFF, 16'h0000);
        wait_drain();
        chk("pre_rst_sat", sat_cnt, 1);
        send_exp(16'h1234, 16'h0005, 3'b000, 16'h1234, 16'h0005);
        send_exp(16'h0042, 16'hFFF0, 3'b000, 16'h0042, 16'hFFF0);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sat", sat_cnt, 0);
        chk("mid_rst_out_i", out_i, 0);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_ready", in_ready, 1);
        chk("post_rst_flush", out_valid, 0);
        send_exp(16'h0100, 16'hFF00, 3'b001, 16'h0200, 16'hFE00);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
